// File: rtl/clock_period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clock_period_meter: measures sclk_in period in clk cycles, tracks  |
// | lock against an expected period and flags a stalled sclk_in.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+

module clock_period_meter #(
  parameter int unsigned EXP_PERIOD = 18000002,
  parameter int unsigned TOL        = 1000,
  parameter int unsigned TIMEOUT    = 36000004,
  parameter int unsigned LOCK_N     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk_in,
  output logic        tick,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        locked,
  output logic        timeout,
  output logic [7:0]  err_count
);

  localparam logic [1:0]  c_IDLE    = 2'd0;
  localparam logic [1:0]  c_ARMED   = 2'd1;
  localparam logic [1:0]  c_TRACK   = 2'd2;
  localparam logic [1:0]  c_LOCKED  = 2'd3;
  localparam logic [31:0] c_EXP     = 32'(EXP_PERIOD);
  localparam logic [31:0] c_TOL     = 32'(TOL);
  localparam logic [31:0] c_TIMEOUT = 32'(TIMEOUT);
  localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;
  localparam logic [3:0]  c_LOCK_N  = 4'(LOCK_N);

  logic        r_sync1, r_sync2, r_sync3;
  logic [1:0]  r_fill;
  logic        r_seen_low;
  logic        r_tick;
  logic [1:0]  r_state, w_state_nxt;
  logic [31:0] r_cnt, r_period;
  logic [3:0]  r_hit, w_hit_nxt, w_hit_inc;
  logic [7:0]  r_err;
  logic        r_pv, r_locked, r_timeout;
  logic        w_rise, w_timeout_hit, w_in_range, w_load, w_err_inc;
  logic [31:0] w_cnt_inc, w_diff;

  // A rise only counts once a genuine low has been sampled since reset,
  // so a high level present at reset release is not mistaken for an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync3    <= 1'b0;
      r_fill     <= 2'b00;
      r_seen_low <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_sync1 <= sclk_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_fill  <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_sync2)
        r_seen_low <= 1'b1;
      r_tick <= w_rise;
    end
  end

  assign w_rise        = r_sync2 & ~r_sync3 & r_seen_low;
  assign w_cnt_inc     = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 32'd1;
  assign w_diff        = (w_cnt_inc >= c_EXP) ? (w_cnt_inc - c_EXP) : (c_EXP - w_cnt_inc);
  assign w_in_range    = (w_diff <= c_TOL);
  assign w_timeout_hit = ~w_rise & (w_cnt_inc >= c_TIMEOUT);
  assign w_hit_inc     = (r_state == c_ARMED) ? 4'd1 : r_hit + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_rise) begin
      case (r_state)
        c_IDLE:           w_state_nxt = c_ARMED;
        c_ARMED, c_TRACK: w_state_nxt = (w_in_range && (w_hit_inc >= c_LOCK_N)) ? c_LOCKED : c_TRACK;
        c_LOCKED:         w_state_nxt = w_in_range ? c_LOCKED : c_TRACK;
        default:          w_state_nxt = c_IDLE;
      endcase
    end else if (w_timeout_hit) begin
      w_state_nxt = c_IDLE;
    end
  end

  always_comb begin
    w_load    = 1'b0;
    w_err_inc = 1'b0;
    w_hit_nxt = r_hit;
    if (w_rise) begin
      if (r_state != c_IDLE) begin
        w_load = 1'b1;
        if (w_in_range) begin
          if (r_state != c_LOCKED)
            w_hit_nxt = w_hit_inc;
        end else begin
          w_hit_nxt = 4'd0;
          w_err_inc = 1'b1;
        end
      end
    end else if (w_timeout_hit) begin
      w_hit_nxt = 4'd0;
    end
  end

  // cnt+1 at a rise is exactly the clk cycles since the previous rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= 32'd0;
      r_hit     <= 4'd0;
      r_period  <= 32'd0;
      r_pv      <= 1'b0;
      r_err     <= 8'd0;
      r_timeout <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_cnt    <= w_rise ? 32'd0 : w_cnt_inc;
      r_hit    <= w_hit_nxt;
      r_pv     <= w_load;
      r_locked <= (r_state == c_LOCKED);
      if (w_load)
        r_period <= w_cnt_inc;
      if (w_err_inc && (r_err != 8'hFF))
        r_err <= r_err + 8'd1;
      if (w_timeout_hit)
        r_timeout <= 1'b1;
      else if (r_tick)
        r_timeout <= 1'b0;
    end
  end

  assign tick         = r_tick;
  assign period       = r_period;
  assign period_valid = r_pv;
  assign locked       = r_locked;
  assign timeout      = r_timeout;
  assign err_count    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_clock_period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_clock_period_meter: directed scenarios for clock_period_meter.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+

module tb_clock_period_meter;

  logic        clk;
  logic        reset;
  logic        sclk_in;
  logic        tick;
  logic [31:0] period;
  logic        period_valid;
  logic        locked;
  logic        timeout;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations from the most recent edge_after call (k = steps after sclk_in rise).
  int          e_lat, e_nt;
  logic        e_pv3, e_pv4, e_lk3, e_lk4, e_to3, e_to4;
  logic [31:0] e_per3;
  logic [7:0]  e_err4;

  clock_period_meter #(
    .EXP_PERIOD(20),
    .TOL(2),
    .TIMEOUT(50),
    .LOCK_N(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sclk_in(sclk_in),
    .tick(tick),
    .period(period),
    .period_valid(period_valid),
    .locked(locked),
    .timeout(timeout),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raises sclk_in p cycles after the previous rise, then observes 4 cycles.
  task automatic edge_after(input int p);
    e_lat = 0;
    e_nt  = 0;
    for (int j = 0; j < p - 4; j++) begin
      step();
      if (tick) e_nt++;
    end
    sclk_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (tick) begin
        e_nt++;
        if (e_lat == 0) e_lat = k;
      end
      if (k == 3) begin
        e_pv3 = period_valid; e_per3 = period; e_lk3 = locked; e_to3 = timeout;
      end
      if (k == 4) begin
        e_pv4 = period_valid; e_lk4 = locked; e_to4 = timeout; e_err4 = err_count;
      end
    end
    sclk_in = 1'b0;
  endtask

  task automatic test_reset();
    int nt;
    reset   = 1'b0;
    sclk_in = 1'b1;
    repeat (3) step();
    n_cmp++; if (tick !== 1'b0)         begin n_bad++; $display("FAIL rst_tick: got %0b expected 0", tick); end
    n_cmp++; if (period !== 32'd0)      begin n_bad++; $display("FAIL rst_period: got %0d expected 0", period); end
    n_cmp++; if (period_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pv: got %0b expected 0", period_valid); end
    n_cmp++; if (locked !== 1'b0)       begin n_bad++; $display("FAIL rst_locked: got %0b expected 0", locked); end
    n_cmp++; if (timeout !== 1'b0)      begin n_bad++; $display("FAIL rst_timeout: got %0b expected 0", timeout); end
    n_cmp++; if (err_count !== 8'd0)    begin n_bad++; $display("FAIL rst_err: got %0d expected 0", err_count); end
    reset = 1'b1;
    nt = 0;
    repeat (8) begin step(); if (tick) nt++; end
    sclk_in = 1'b0;
    repeat (4) begin step(); if (tick) nt++; end
    n_cmp++; if (nt !== 0) begin n_bad++; $display("FAIL high_at_release_tick: got %0d ticks expected 0", nt); end
  endtask

  task automatic test_lock();
    edge_after(6);
    n_cmp++; if (e_lat !== 3)    begin n_bad++; $display("FAIL tick_latency: got %0d expected 3", e_lat); end
    n_cmp++; if (e_nt !== 1)     begin n_bad++; $display("FAIL tick_width: got %0d ticks expected 1", e_nt); end
    n_cmp++; if (e_pv3 !== 1'b0) begin n_bad++; $display("FAIL idle_no_pv: got %0b expected 0", e_pv3); end
    edge_after(20);
    n_cmp++; if (e_pv3 !== 1'b1)   begin n_bad++; $display("FAIL edge2_pv: got %0b expected 1", e_pv3); end
    n_cmp++; if (e_per3 !== 32'd20) begin n_bad++; $display("FAIL edge2_period: got %0d expected 20", e_per3); end
    n_cmp++; if (e_pv4 !== 1'b0)   begin n_bad++; $display("FAIL pv_one_cycle: got %0b expected 0", e_pv4); end
    n_cmp++; if (e_lk4 !== 1'b0)   begin n_bad++; $display("FAIL edge2_locked: got %0b expected 0", e_lk4); end
    edge_after(20);
    n_cmp++; if (e_per3 !== 32'd20) begin n_bad++; $display("FAIL edge3_period: got %0d expected 20", e_per3); end
    n_cmp++; if (e_lk3 !== 1'b0)   begin n_bad++; $display("FAIL edge3_locked_at_tick: got %0b expected 0", e_lk3); end
    n_cmp++; if (e_lk4 !== 1'b1)   begin n_bad++; $display("FAIL edge3_locked_after: got %0b expected 1", e_lk4); end
    edge_after(20);
    n_cmp++; if (e_pv3 !== 1'b1)   begin n_bad++; $display("FAIL edge4_pv: got %0b expected 1", e_pv3); end
    n_cmp++; if (e_lk4 !== 1'b1)   begin n_bad++; $display("FAIL edge4_locked: got %0b expected 1", e_lk4); end
    n_cmp++; if (e_err4 !== 8'd0)  begin n_bad++; $display("FAIL edge4_err: got %0d expected 0", e_err4); end
  endtask

  task automatic test_relock();
    edge_after(23);
    n_cmp++; if (e_per3 !== 32'd23) begin n_bad++; $display("FAIL p23_period: got %0d expected 23", e_per3); end
    n_cmp++; if (e_err4 !== 8'd1)   begin n_bad++; $display("FAIL p23_err: got %0d expected 1", e_err4); end
    n_cmp++; if (e_lk4 !== 1'b0)    begin n_bad++; $display("FAIL p23_unlock: got %0b expected 0", e_lk4); end
    edge_after(20);
    n_cmp++; if (e_lk4 !== 1'b0)    begin n_bad++; $display("FAIL relock_first: got %0b expected 0", e_lk4); end
    edge_after(20);
    n_cmp++; if (e_lk4 !== 1'b1)    begin n_bad++; $display("FAIL relock_second: got %0b expected 1", e_lk4); end
  endtask

  task automatic test_boundaries();
    edge_after(22);
    n_cmp++; if (e_err4 !== 8'd1)   begin n_bad++; $display("FAIL p22_err: got %0d expected 1", e_err4); end
    n_cmp++; if (e_lk4 !== 1'b1)    begin n_bad++; $display("FAIL p22_locked: got %0b expected 1", e_lk4); end
    edge_after(18);
    n_cmp++; if (e_per3 !== 32'd18) begin n_bad++; $display("FAIL p18_period: got %0d expected 18", e_per3); end
    n_cmp++; if (e_err4 !== 8'd1)   begin n_bad++; $display("FAIL p18_err: got %0d expected 1", e_err4); end
    n_cmp++; if (e_lk4 !== 1'b1)    begin n_bad++; $display("FAIL p18_locked: got %0b expected 1", e_lk4); end
    edge_after(17);
    n_cmp++; if (e_per3 !== 32'd17) begin n_bad++; $display("FAIL p17_period: got %0d expected 17", e_per3); end
    n_cmp++; if (e_err4 !== 8'd2)   begin n_bad++; $display("FAIL p17_err: got %0d expected 2", e_err4); end
    n_cmp++; if (e_lk4 !== 1'b0)    begin n_bad++; $display("FAIL p17_locked: got %0b expected 0", e_lk4); end
    edge_after(20);
    edge_after(23);
    n_cmp++; if (e_err4 !== 8'd3)   begin n_bad++; $display("FAIL p23b_err: got %0d expected 3", e_err4); end
    n_cmp++; if (e_lk4 !== 1'b0)    begin n_bad++; $display("FAIL p23b_locked: got %0b expected 0", e_lk4); end
    edge_after(20);
    edge_after(20);
    n_cmp++; if (e_lk4 !== 1'b1)    begin n_bad++; $display("FAIL bnd_relock: got %0b expected 1", e_lk4); end
  endtask

  task automatic test_timeout();
    for (int j = 1; j <= 50; j++) begin
      step();
      if (j == 48) begin
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_early: got %0b expected 0", timeout); end
      end
      if (j == 49) begin
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_set: got %0b expected 1", timeout); end
        n_cmp++; if (locked !== 1'b1)  begin n_bad++; $display("FAIL to_locked_same: got %0b expected 1", locked); end
      end
      if (j == 50) begin
        n_cmp++; if (locked !== 1'b0)  begin n_bad++; $display("FAIL to_locked_drop: got %0b expected 0", locked); end
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %0b expected 1", timeout); end
      end
    end
    edge_after(4);
    n_cmp++; if (e_lat !== 3)    begin n_bad++; $display("FAIL to_tick_latency: got %0d expected 3", e_lat); end
    n_cmp++; if (e_pv3 !== 1'b0) begin n_bad++; $display("FAIL to_no_pv: got %0b expected 0", e_pv3); end
    n_cmp++; if (e_to3 !== 1'b1) begin n_bad++; $display("FAIL to_hold_at_tick: got %0b expected 1", e_to3); end
    n_cmp++; if (e_to4 !== 1'b0) begin n_bad++; $display("FAIL to_cleared: got %0b expected 0", e_to4); end
  endtask

  // A rise landing exactly on the timeout cycle must be measured, not timed out.
  task automatic test_tick_priority();
    edge_after(50);
    n_cmp++; if (e_pv3 !== 1'b1)    begin n_bad++; $display("FAIL prio_pv: got %0b expected 1", e_pv3); end
    n_cmp++; if (e_per3 !== 32'd50) begin n_bad++; $display("FAIL prio_period: got %0d expected 50", e_per3); end
    n_cmp++; if (e_to3 !== 1'b0)    begin n_bad++; $display("FAIL prio_timeout: got %0b expected 0", e_to3); end
    n_cmp++; if (e_err4 !== 8'd4)   begin n_bad++; $display("FAIL prio_err: got %0d expected 4", e_err4); end
  endtask

  task automatic test_reset_async();
    edge_after(20);
    edge_after(20);
    n_cmp++; if (e_lk4 !== 1'b1) begin n_bad++; $display("FAIL pre_reset_locked: got %0b expected 1", e_lk4); end
    step();
    #3;
    reset = 1'b0;
    #1;
    n_cmp++; if (tick !== 1'b0)         begin n_bad++; $display("FAIL arst_tick: got %0b expected 0", tick); end
    n_cmp++; if (period !== 32'd0)      begin n_bad++; $display("FAIL arst_period: got %0d expected 0", period); end
    n_cmp++; if (period_valid !== 1'b0) begin n_bad++; $display("FAIL arst_pv: got %0b expected 0", period_valid); end
    n_cmp++; if (locked !== 1'b0)       begin n_bad++; $display("FAIL arst_locked: got %0b expected 0", locked); end
    n_cmp++; if (timeout !== 1'b0)      begin n_bad++; $display("FAIL arst_timeout: got %0b expected 0", timeout); end
    n_cmp++; if (err_count !== 8'd0)    begin n_bad++; $display("FAIL arst_err: got %0d expected 0", err_count); end
    sclk_in = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic test_saturation();
    edge_after(6);
    for (int i = 1; i <= 300; i++) begin
      edge_after(6);
      if (i == 1) begin
        n_cmp++; if (e_per3 !== 32'd6) begin n_bad++; $display("FAIL sat_period: got %0d expected 6", e_per3); end
      end
      if (i == 10) begin
        n_cmp++; if (e_err4 !== 8'd10) begin n_bad++; $display("FAIL sat_err10: got %0d expected 10", e_err4); end
      end
      if (i == 255) begin
        n_cmp++; if (e_err4 !== 8'd255) begin n_bad++; $display("FAIL sat_err255: got %0d expected 255", e_err4); end
      end
    end
    n_cmp++; if (e_err4 !== 8'd255) begin n_bad++; $display("FAIL sat_err300: got %0d expected 255", e_err4); end
    repeat (5) edge_after(6);
    n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d expected 255", err_count); end
  endtask

  initial begin
    reset   = 1'b0;
    sclk_in = 1'b0;
    test_reset();
    test_lock();
    test_relock();
    test_boundaries();
    test_timeout();
    test_tick_priority();
    test_reset_async();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
